psum_accum_writer: RTL and testbench

Write-side controller for the three-line partial-sum RAM bank. It accepts three lines of per-time-step partial sums from the PE array and assigns each beat a linear pixel address. On the first input-channel pass it writes the beat straight into the RAM. On later passes it reads back the stored psum, adds lane-wise and writes the result back. It sits between the PE array output and the psum RAM write/read-three-lines ports.

---
 rtl/psum_accum_writer.sv | 155 +++++++++++++++
 tb/tb_psum_accum_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_writer.sv
// rtl/psum_accum_writer.sv - write-side controller: overwrite or accumulate PE psum lines into the three-line RAM.
// Optional macro PSUM_SAT_EN: lane adds saturate instead of wrapping.
module psum_accum_writer #(
    parameter int ADDR_W = 9,
    parameter int LANE_W = 12,
    parameter int T      = 4,
    parameter int RD_LAT = 2
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  code_valid,
    input  logic [15:0]           conv_img_size,
    input  logic                  start,
    input  logic                  first_pass,
    input  logic                  pe_valid,
    output logic                  pe_ready,
    input  logic [LANE_W*T-1:0]   pe_line0,
    input  logic [LANE_W*T-1:0]   pe_line1,
    input  logic [LANE_W*T-1:0]   pe_line2,
    output logic                  ram_rd_req,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    output logic                  ram_rd_mode,
    input  logic [LANE_W*T-1:0]   ram_rd_line0,
    input  logic [LANE_W*T-1:0]   ram_rd_line1,
    input  logic [LANE_W*T-1:0]   ram_rd_line2,
    output logic                  ram_wr_valid,
    output logic [ADDR_W-1:0]     ram_wr_addr,
    output logic [LANE_W*T-1:0]   ram_wr_line0,
    output logic [LANE_W*T-1:0]   ram_wr_line1,
    output logic [LANE_W*T-1:0]   ram_wr_line2,
    output logic                  busy,
    output logic                  pass_done
);
    localparam int W = LANE_W * T;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [15:0]         img_size;
    logic [15:0]         len_m1;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   last_addr;
    logic                fp_r;
    logic                accept;
    logic                unused_len;

    logic [RD_LAT-1:0]   vld;
    logic [W-1:0]        dl0 [RD_LAT];
    logic [W-1:0]        dl1 [RD_LAT];
    logic [W-1:0]        dl2 [RD_LAT];
    logic [ADDR_W-1:0]   dla [RD_LAT];

    // Last address of the pass is L-1 = size-3; only the low ADDR_W bits address the RAM.
    assign len_m1     = img_size - 16'd3;
    assign last_addr  = len_m1[ADDR_W-1:0];
    assign unused_len = ^len_m1[15:ADDR_W];

    assign accept      = pe_valid && pe_ready;
    assign ram_rd_req  = accept;
    assign ram_rd_addr = addr;
    assign ram_rd_mode = 1'b0;
    assign busy        = (state != IDLE) || (|vld) || ram_wr_valid;

    function automatic logic [W-1:0] add_line(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < T; i++) begin
`ifdef PSUM_SAT_EN
            logic [LANE_W:0] s;
            s = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, b[i*LANE_W +: LANE_W]};
            r[i*LANE_W +: LANE_W] = s[LANE_W] ? {LANE_W{1'b1}} : s[LANE_W-1:0];
`else
            r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
`endif
        end
        return r;
    endfunction

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state     <= IDLE;
            img_size  <= '0;
            addr      <= '0;
            fp_r      <= 1'b0;
            pe_ready  <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            if (code_valid)
                img_size <= conv_img_size;
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    fp_r     <= first_pass;
                    addr     <= '0;
                    pe_ready <= 1'b1;
                end
                RUN: if (accept) begin
                    if (addr == last_addr) begin
                        state    <= DRAIN;
                        addr     <= '0;
                        pe_ready <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                // Delay line empty means the final write is on the port this cycle.
                DRAIN: if (!(|vld)) begin
                    state     <= IDLE;
                    pass_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            vld          <= '0;
            ram_wr_valid <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_line0 <= '0;
            ram_wr_line1 <= '0;
            ram_wr_line2 <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                dl0[k] <= '0;
                dl1[k] <= '0;
                dl2[k] <= '0;
                dla[k] <= '0;
            end
        end else begin
            vld[0] <= accept;
            if (accept) begin
                dl0[0] <= pe_line0;
                dl1[0] <= pe_line1;
                dl2[0] <= pe_line2;
                dla[0] <= addr;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                vld[k] <= vld[k-1];
                dl0[k] <= dl0[k-1];
                dl1[k] <= dl1[k-1];
                dl2[k] <= dl2[k-1];
                dla[k] <= dla[k-1];
            end
            ram_wr_valid <= vld[RD_LAT-1];
            if (vld[RD_LAT-1]) begin
                ram_wr_addr  <= dla[RD_LAT-1];
                ram_wr_line0 <= add_line(dl0[RD_LAT-1], fp_r ? '0 : ram_rd_line0);
                ram_wr_line1 <= add_line(dl1[RD_LAT-1], fp_r ? '0 : ram_rd_line1);
                ram_wr_line2 <= add_line(dl2[RD_LAT-1], fp_r ? '0 : ram_rd_line2);
            end
        end
    end
endmodule

// File: tb/tb_psum_accum_writer.sv
// tb/tb_psum_accum_writer.sv - directed bench for psum_accum_writer with a two-cycle RAM model.
module tb_psum_accum_writer;
    logic        s_clk = 1'b0;
    logic        s_rst;
    logic        code_valid, start, first_pass, pe_valid, pe_ready;
    logic [15:0] conv_img_size;
    logic [47:0] pe_line0, pe_line1, pe_line2;
    logic        ram_rd_req, ram_rd_mode, ram_wr_valid, busy, pass_done;
    logic [8:0]  ram_rd_addr, ram_wr_addr;
    logic [47:0] ram_rd_line0, ram_rd_line1, ram_rd_line2;
    logic [47:0] ram_wr_line0, ram_wr_line1, ram_wr_line2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc;
    int acc_cyc[$];
    int wr_cyc[$];
    int wr_addr[$];
    logic [47:0] wr_l0[$], wr_l1[$], wr_l2[$];

    logic [47:0] mem0 [512], mem1 [512], mem2 [512];
    logic [47:0] rq0, rq1, rq2, rp0, rp1, rp2;

    psum_accum_writer dut (
        .s_clk(s_clk), .s_rst(s_rst), .code_valid(code_valid), .conv_img_size(conv_img_size),
        .start(start), .first_pass(first_pass), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .pe_line0(pe_line0), .pe_line1(pe_line1), .pe_line2(pe_line2),
        .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr), .ram_rd_mode(ram_rd_mode),
        .ram_rd_line0(ram_rd_line0), .ram_rd_line1(ram_rd_line1), .ram_rd_line2(ram_rd_line2),
        .ram_wr_valid(ram_wr_valid), .ram_wr_addr(ram_wr_addr),
        .ram_wr_line0(ram_wr_line0), .ram_wr_line1(ram_wr_line1), .ram_wr_line2(ram_wr_line2),
        .busy(busy), .pass_done(pass_done)
    );

    always #5 s_clk = ~s_clk;

    always @(posedge s_clk) begin
        cyc <= cyc + 1;
        if (ram_rd_req) begin
            rq0 <= mem0[ram_rd_addr];
            rq1 <= mem1[ram_rd_addr];
            rq2 <= mem2[ram_rd_addr];
        end
        rp0 <= rq0;
        rp1 <= rq1;
        rp2 <= rq2;
        if (ram_wr_valid) begin
            mem0[ram_wr_addr] <= ram_wr_line0;
            mem1[ram_wr_addr] <= ram_wr_line1;
            mem2[ram_wr_addr] <= ram_wr_line2;
        end
    end
    assign ram_rd_line0 = rp0;
    assign ram_rd_line1 = rp1;
    assign ram_rd_line2 = rp2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge s_clk);
        #1;
    endtask

    always @(negedge s_clk) begin
        if (!s_rst) begin
            if (pe_valid && pe_ready) begin
                check("rd_req", ram_rd_req, 1);
                check("rd_addr", ram_rd_addr, acc_cyc.size());
                check("rd_mode", ram_rd_mode, 0);
                acc_cyc.push_back(cyc);
            end
            if (ram_wr_valid) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(int'(ram_wr_addr));
                wr_l0.push_back(ram_wr_line0);
                wr_l1.push_back(ram_wr_line1);
                wr_l2.push_back(ram_wr_line2);
            end
            if (pass_done) begin
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic set_size(input logic [15:0] sz);
        conv_img_size = sz;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic clear_log;
        acc_cyc.delete(); wr_cyc.delete(); wr_addr.delete();
        wr_l0.delete(); wr_l1.delete(); wr_l2.delete();
        done_cyc = -1;
    endtask

    // pat bit i is pe_valid in the i-th cycle after start; a start pulse in cycle 1 must be ignored.
    task automatic run_pass(input logic fp, input logic [7:0] pat, input int n,
                            input logic [47:0] v0, input logic [47:0] v1, input logic [47:0] v2);
        clear_log();
        start = 1'b1;
        first_pass = fp;
        tick();
        start = 1'b0;
        check("ready_in_run", pe_ready, 1);
        pe_line0 = v0;
        pe_line1 = v1;
        pe_line2 = v2;
        for (int i = 0; i < n; i++) begin
            pe_valid = pat[i];
            start = (i == 1);
            first_pass = (i == 1) ? 1'b1 : fp;
            tick();
        end
        pe_valid = 1'b0;
        start = 1'b0;
        check("ready_drain", pe_ready, 0);
        check("busy_drain", busy, 1);
        for (int k = 0; k < 20 && done_cyc < 0; k++)
            tick();
        if (done_cyc < 0)
            check("done_timeout", 0, 1);
    endtask

    task automatic check_writes(input int n, input logic [47:0] e0, input logic [47:0] e1, input logic [47:0] e2);
        check("n_acc", acc_cyc.size(), n);
        check("n_wr", wr_cyc.size(), n);
        for (int i = 0; i < n && i < wr_cyc.size() && i < acc_cyc.size(); i++) begin
            check("wr_addr", wr_addr[i], i);
            check("wr_latency", wr_cyc[i] - acc_cyc[i], 3);
            check("wr_line0", wr_l0[i], e0);
            check("wr_line1", wr_l1[i], e1);
            check("wr_line2", wr_l2[i], e2);
        end
        if (wr_cyc.size() > 0)
            check("done_after_wr", done_cyc - wr_cyc[wr_cyc.size()-1], 1);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            mem0[a] = '0; mem1[a] = '0; mem2[a] = '0;
        end
        s_rst = 1'b1;
        code_valid = 1'b0; conv_img_size = '0; start = 1'b0; first_pass = 1'b0;
        pe_valid = 1'b0; pe_line0 = '0; pe_line1 = '0; pe_line2 = '0;
        done_cyc = -1;
        tick(); tick();
        check("rst_pe_ready", pe_ready, 0);
        check("rst_rd_req", ram_rd_req, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_wr_valid", ram_wr_valid, 0);
        check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_wr_line0", ram_wr_line0, 0);
        check("rst_busy", busy, 0);
        check("rst_pass_done", pass_done, 0);
        s_rst = 1'b0;
        tick();

        set_size(16'd6);
        run_pass(1'b1, 8'b1111, 4, 48'h005005005005, 48'h005005005005, 48'h005005005005);
        check_writes(4, 48'h005005005005, 48'h005005005005, 48'h005005005005);

        run_pass(1'b0, 8'b1111, 4, 48'h007007007007, 48'h007007007007, 48'h007007007007);
        check_writes(4, 48'h00C00C00C00C, 48'h00C00C00C00C, 48'h00C00C00C00C);

        run_pass(1'b1, 8'b1111, 4, 48'hFFFFFF123FFF, 48'h800800800800, 48'h000000000000);
        check_writes(4, 48'hFFFFFF123FFF, 48'h800800800800, 48'h000000000000);

        run_pass(1'b0, 8'b1111, 4, 48'h001000001001, 48'h8007FF001000, 48'hABCDEF012345);
`ifdef PSUM_SAT_EN
        check_writes(4, 48'hFFFFFF124FFF, 48'hFFFFFF801800, 48'hABCDEF012345);
`else
        check_writes(4, 48'h000FFF124000, 48'h000FFF801800, 48'hABCDEF012345);
`endif

        run_pass(1'b0, 8'b11101, 5, 48'h001001001001, 48'h001001001001, 48'h001001001001);
`ifdef PSUM_SAT_EN
        check_writes(4, 48'hFFFFFF125FFF, 48'hFFFFFF802801, 48'hABDDF0013346);
`else
        check_writes(4, 48'h001000125001, 48'h001000802801, 48'hABDDF0013346);
`endif
        if (acc_cyc.size() >= 2 && wr_cyc.size() >= 3) begin
            check("bubble_acc_gap", acc_cyc[1] - acc_cyc[0], 2);
            check("bubble_wr_gap", wr_cyc[1] - wr_cyc[0], 2);
            check("b2b_wr_gap", wr_cyc[2] - wr_cyc[1], 1);
        end

        set_size(16'd3);
        run_pass(1'b1, 8'b1, 1, 48'h111111111111, 48'h222222222222, 48'h333333333333);
        check_writes(1, 48'h111111111111, 48'h222222222222, 48'h333333333333);

        set_size(16'd6);
        clear_log();
        start = 1'b1; first_pass = 1'b1;
        tick();
        start = 1'b0;
        pe_valid = 1'b1;
        tick(); tick();
        pe_valid = 1'b0;
        s_rst = 1'b1;
        #1;
        check("mid_rst_pe_ready", pe_ready, 0);
        check("mid_rst_rd_req", ram_rd_req, 0);
        check("mid_rst_wr_valid", ram_wr_valid, 0);
        check("mid_rst_wr_line0", ram_wr_line0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_acc", acc_cyc.size(), 2);
        tick(); tick();
        s_rst = 1'b0;
        for (int k = 0; k < 8; k++)
            tick();
        check("post_rst_no_wr", wr_cyc.size(), 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", pe_ready, 0);
        check("post_rst_done", done_cyc, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
